// File: rtl/prbs_seq_ctrl_if.sv
// Handshake/status bundle between the PRBS sequencer and its test harness.
// slave is the sequencer side; master drives START and the received word stream.
interface prbs_seq_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             START;
  logic [WIDTH-1:0] I_DATA;
  logic             I_VALID;
  logic             O_GEN_RST;
  logic             O_GEN_CE;
  logic             O_BUSY;
  logic             O_LOCKED;
  logic             O_DONE;
  logic             O_PASS;
  logic [15:0]      O_ERR_COUNT;
  logic [31:0]      O_WORD_COUNT;

  modport master (
    output START, I_DATA, I_VALID,
    input  O_GEN_RST, O_GEN_CE, O_BUSY, O_LOCKED, O_DONE, O_PASS,
           O_ERR_COUNT, O_WORD_COUNT
  );

  modport slave (
    input  START, I_DATA, I_VALID,
    output O_GEN_RST, O_GEN_CE, O_BUSY, O_LOCKED, O_DONE, O_PASS,
           O_ERR_COUNT, O_WORD_COUNT
  );
endinterface

// File: rtl/prbs_seq_ctrl.sv
// PRBS loopback sequencer: resets/enables the generator LFSR, self-synchronises
// on the returned word stream, then checks a fixed-length run against a free-running reference.
module prbs_seq_ctrl #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] POLY        = WIDTH'(16'hD008),
  parameter int unsigned      LOCK_COUNT  = 8,
  parameter int unsigned      RUN_LEN     = 1024,
  parameter int unsigned      ACQ_TIMEOUT = 4096
) (
  input  logic           CLK,
  input  logic           RST,
  prbs_seq_ctrl_if.slave bus
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned TW = $clog2(ACQ_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_GEN,
    S_ACQUIRE,
    S_CHECK,
    S_DONE
  } state_e;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], ^(x & POLY)};
  endfunction

  state_e           state_q, state_d;
  logic [MW-1:0]    match_q, match_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             have_prev_q, have_prev_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic             locked_q, locked_d;
  logic [15:0]      err_q, err_d;
  logic [31:0]      word_q, word_d;
  logic             gen_rst_q, gen_rst_d;
  logic             gen_ce_q, gen_ce_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             match;
  logic [MW-1:0]    match_inc;

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    tmo_d       = tmo_q;
    have_prev_d = have_prev_q;
    prev_d      = prev_q;
    ref_d       = ref_q;
    locked_d    = locked_q;
    err_d       = err_q;
    word_d      = word_q;

    match     = have_prev_q && (bus.I_DATA == lfsr_next(prev_q)) && (bus.I_DATA != '0);
    match_inc = match_q + MW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (bus.START) state_d = S_RESET_GEN;
      end
      S_RESET_GEN: begin
        state_d = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        tmo_d = tmo_q + TW'(1);
        if (bus.I_VALID) begin
          prev_d      = bus.I_DATA;
          have_prev_d = 1'b1;
          match_d     = match ? match_inc : '0;
        end
        if (bus.I_VALID && match && (match_inc == MW'(LOCK_COUNT))) begin
          locked_d = 1'b1;
          ref_d    = lfsr_next(bus.I_DATA);
          state_d  = S_CHECK;
        end else if (tmo_d == TW'(ACQ_TIMEOUT)) begin
          state_d = S_DONE;
        end
      end
      S_CHECK: begin
        if (bus.I_VALID) begin
          if ((bus.I_DATA != ref_q) && (err_q != '1)) err_d = err_q + 16'd1;
          ref_d  = lfsr_next(ref_q);
          word_d = word_q + 32'd1;
          if (word_d == 32'(RUN_LEN)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.START) state_d = S_RESET_GEN;
      end
      default: state_d = S_IDLE;
    endcase

    // Run state is cleared on entry to RESET_GEN so the registered status
    // outputs already read zero during the generator-reset cycle.
    if (RST || ((state_d == S_RESET_GEN) && (state_q != S_RESET_GEN))) begin
      match_d     = '0;
      tmo_d       = '0;
      have_prev_d = 1'b0;
      locked_d    = 1'b0;
      err_d       = '0;
      word_d      = '0;
    end
    if (RST) begin
      state_d = S_IDLE;
      prev_d  = '0;
      ref_d   = '0;
    end

    gen_rst_d = (state_d == S_RESET_GEN);
    gen_ce_d  = (state_d == S_ACQUIRE) || (state_d == S_CHECK);
    busy_d    = (state_d == S_RESET_GEN) || gen_ce_d;
    done_d    = (state_d == S_DONE);
    pass_d    = done_d && locked_d && (err_d == '0);
  end

  always_ff @(posedge CLK) begin
    state_q     <= state_d;
    match_q     <= match_d;
    tmo_q       <= tmo_d;
    have_prev_q <= have_prev_d;
    prev_q      <= prev_d;
    ref_q       <= ref_d;
    locked_q    <= locked_d;
    err_q       <= err_d;
    word_q      <= word_d;
    gen_rst_q   <= gen_rst_d;
    gen_ce_q    <= gen_ce_d;
    busy_q      <= busy_d;
    done_q      <= done_d;
    pass_q      <= pass_d;
  end

  assign bus.O_GEN_RST    = gen_rst_q;
  assign bus.O_GEN_CE     = gen_ce_q;
  assign bus.O_BUSY       = busy_q;
  assign bus.O_LOCKED     = locked_q;
  assign bus.O_DONE       = done_q;
  assign bus.O_PASS       = pass_q;
  assign bus.O_ERR_COUNT  = err_q;
  assign bus.O_WORD_COUNT = word_q;

endmodule

// File: doc/prbs_seq_ctrl.md
# prbs_seq_ctrl

PRBS test sequencer for the serializer loopback minitests. It sequences a generator LFSR instance by driving its CE and RST. It acquires lock on the received word stream by self-synchronising prediction, then checks a fixed-length run against a free-running reference LFSR, counts word errors and reports pass/fail. It sits between the generator LFSR feeding the OSERDES and the deserialized return path.

## Interface

Parameters:
- WIDTH, 16, LFSR / data word width (≥2)
- POLY, 16'hD008, feedback polynomial, identical to the generator's
- LOCK_COUNT, 8, consecutive correct predictions required to declare lock (≥1)
- RUN_LEN, 1024, number of words checked after lock (≥1, <2^32)
- ACQ_TIMEOUT, 4096, CLK cycles allowed in ACQUIRE before aborting (≥1)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- START  in  1  single-cycle start request
- I_DATA  in  WIDTH  received word
- I_VALID  in  1  I_DATA qualifier
- O_GEN_RST  out  1  to generator RST
- O_GEN_CE  out  1  to generator CE
- O_BUSY  out  1  high in RESET_GEN, ACQUIRE, CHECK
- O_LOCKED  out  1  lock achieved in current run
- O_DONE  out  1  run finished (level)
- O_PASS  out  1  valid when O_DONE: locked and zero errors
- O_ERR_COUNT  out  16  mismatched words, saturates at 16'hFFFF
- O_WORD_COUNT  out  32  words checked in CHECK

## Operation

- next(x) = {x[WIDTH-2:0], ^(x & POLY)}, the generator's step function.
- States: IDLE, RESET_GEN, ACQUIRE, CHECK, DONE. All outputs are registered.
- IDLE: all outputs 0. START → RESET_GEN.
- RESET_GEN (exactly 1 cycle):
  - O_GEN_RST=1, O_GEN_CE=0.
  - Clears LOCKED, DONE, PASS, ERR_COUNT, WORD_COUNT, the match counter, the timeout counter and have_prev.
  - → ACQUIRE.
- ACQUIRE: O_GEN_CE=1. For each I_VALID word:
  - Match: have_prev, I_DATA == next(prev), and I_DATA != 0. A match increments match_cnt. A non-match sets match_cnt=0.
  - prev<=I_DATA and have_prev<=1 on every valid word.
  - On the match that brings match_cnt to LOCK_COUNT: LOCKED<=1, ref<=next(I_DATA), → CHECK. This word is not counted in WORD_COUNT.
  - The timeout counter increments every cycle in ACQUIRE. When it reaches ACQ_TIMEOUT without lock → DONE with LOCKED=0.
- CHECK: O_GEN_CE=1. For each I_VALID word:
  - If I_DATA != ref, increment ERR_COUNT (saturating).
  - ref<=next(ref) always. The reference free-runs, so a corrupted word costs exactly one error and does not cause re-lock.
  - WORD_COUNT++.
  - When WORD_COUNT becomes RUN_LEN → DONE.
- DONE:
  - O_GEN_CE=0, O_DONE=1, O_PASS = LOCKED && ERR_COUNT==0.
  - Counters hold their values.
  - START → RESET_GEN (new run). Otherwise DONE holds indefinitely.
- START in RESET_GEN, ACQUIRE or CHECK is ignored.
- RST in any state, including mid-run, → IDLE next cycle with every output 0 and all counters cleared. The RST cycle itself drives O_GEN_CE=0.

## Timing

- START accepted at edge n → O_GEN_RST=1 and O_BUSY=1 from cycle n+1 for one cycle. O_GEN_CE=1 from cycle n+2.
- Lock-declaring word accepted at edge k → O_LOCKED=1 from cycle k+1. The first checked word can be accepted at edge k+1.
- RUN_LEN-th checked word accepted at edge m:
  - O_DONE=1, O_BUSY=0 and O_GEN_CE=0 from cycle m+1.
  - O_ERR_COUNT already includes word m.
- The timeout abort asserts O_DONE the cycle after the counter reaches ACQ_TIMEOUT.
- I_VALID low cycles consume no state except the ACQUIRE timeout counter. No throughput limit: one word per cycle.

## Test plan

- Clean loopback: generator (POLY 16'hD008, SEED 1) output fed to I_DATA with I_VALID=1, LOCK_COUNT=8, RUN_LEN=64, START pulse → O_LOCKED rises after 8 matches, O_DONE after 64 checked words, O_ERR_COUNT=0, O_WORD_COUNT=64, O_PASS=1.
- Single bit flip: same as clean loopback, but XOR 16'h0001 into the 10th checked word → O_ERR_COUNT=1, O_PASS=0, O_LOCKED=1.
- No signal: I_DATA held at 16'h0000, ACQ_TIMEOUT=100 → O_DONE at cycle 100 after entering ACQUIRE, O_LOCKED=0, O_PASS=0, O_WORD_COUNT=0.
- Gapped valid: clean loopback with I_VALID toggling every cycle (generator CE gated identically) → same result as clean loopback, with O_DONE delayed accordingly.
- RST mid-CHECK: RST high for one cycle after 20 checked words → all outputs 0 next cycle, state IDLE. A following START runs a fresh pass to O_PASS=1.
- START ignored while busy: START pulsed during CHECK → no O_GEN_RST pulse and counters continue. START in DONE → O_GEN_RST pulse and counters cleared.
